nbody_host: RTL

NBODY_HOST -- requirements
Module: nbody_host

---
 rtl/nbody_host.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nbody_host.sv
// nbody_host: bus initiator that configures, loads, polls and drains the n-body accelerator.
// Defining NBODY_HOST_TIMEOUT_EN bounds the DONE polling to TIMEOUT_POLLS consecutive misses.
module nbody_host #(
  parameter int BODIES        = 512,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 16,
  parameter int POLL_GAP      = 8,
  parameter int TIMEOUT_POLLS = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8:0]            n_bodies,
  input  logic [8:0]            gap,
  input  logic [15:0]           frames,
  output logic                  busy,
  output logic                  error,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_writedata,
  output logic                  m_write,
  output logic                  m_read,
  output logic                  m_chipselect,
  input  logic [DATA_WIDTH-1:0] m_readdata
);

  typedef enum logic [3:0] {
    IDLE, CFG, LOAD, GO, POLL_WAIT, POLL, ACK_SET, FETCH, ACK_CLR, STOP
  } state_t;

  localparam logic [6:0] OP_GO   = 7'h00;
  localparam logic [6:0] OP_READ = 7'h01;
  localparam logic [6:0] OP_NB   = 7'h02;
  localparam logic [6:0] OP_X    = 7'h03;
  localparam logic [6:0] OP_GAP  = 7'h08;
  localparam logic [6:0] OP_DONE = 7'h40;
  localparam logic [6:0] OP_RX   = 7'h41;
  localparam logic [6:0] OP_RY   = 7'h42;

  localparam int BW = (BODIES > 1) ? $clog2(BODIES) : 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  state_t                  state_q, state_d;
  logic [8:0]              n_q;
  logic [8:0]              gap_q;
  logic [BW-1:0]           n_m1_q;
  logic [15:0]             frames_m1_q;
  logic [BW-1:0]           body_q;
  logic [15:0]             frame_q;
  logic [2:0]              idx_q;
  logic [1:0]              ph_q;
  logic                    sel_q;
  logic [GW-1:0]           gcnt_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    error_q;
  logic                    start_ok;
  logic                    body_last;

`ifdef NBODY_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_POLLS + 1);
  logic [TW-1:0]           to_cnt_q;
`endif

  function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [6:0] op, input logic [8:0] b);
    return ADDR_WIDTH'({op, b});
  endfunction

  assign start_ok  = (n_bodies != 9'd0) && (frames != 16'd0);
  assign body_last = (body_q == n_m1_q);

  assign error     = error_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Run configuration, captured once per accepted start
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start && start_ok) begin
      n_q         <= n_bodies;
      n_m1_q      <= BW'(n_bodies - 9'd1);
      gap_q       <= gap;
      frames_m1_q <= frames - 16'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy         = (state_q != IDLE);
    in_ready     = 1'b0;
    m_addr       = '0;
    m_writedata  = '0;
    m_write      = 1'b0;
    m_read       = 1'b0;
    m_chipselect = 1'b0;
    case (state_q)
      IDLE: if (start && start_ok) state_d = CFG;
      CFG: begin
        m_write      = 1'b1;
        m_chipselect = 1'b1;
        case (idx_q)
          3'd0:    m_addr = mk_addr(OP_GO, 9'd0);
          3'd1:    m_addr = mk_addr(OP_READ, 9'd0);
          3'd2: begin
            m_addr      = mk_addr(OP_NB, 9'd0);
            m_writedata = DATA_WIDTH'(n_q);
          end
          default: begin
            m_addr      = mk_addr(OP_GAP, 9'd0);
            m_writedata = DATA_WIDTH'(gap_q);
          end
        endcase
        if (idx_q == 3'd3) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_write      = 1'b1;
          m_chipselect = 1'b1;
          m_addr       = mk_addr(OP_X + 7'(idx_q), 9'(body_q));
          m_writedata  = in_data;
          if (idx_q == 3'd4 && body_last) state_d = GO;
        end
      end
      GO: begin
        m_write      = 1'b1;
        m_chipselect = 1'b1;
        m_addr       = mk_addr(OP_GO, 9'd0);
        m_writedata  = DATA_WIDTH'(1);
        state_d      = POLL_WAIT;
      end
      POLL_WAIT: if (gcnt_q == GW'(POLL_GAP - 1)) state_d = POLL;
      POLL: begin
        m_addr = mk_addr(OP_DONE, 9'd0);
        if (ph_q == 2'd1) begin
          m_read       = 1'b1;
          m_chipselect = 1'b1;
        end
        if (ph_q == 2'd2) begin
          if (m_readdata[0]) state_d = ACK_SET;
`ifdef NBODY_HOST_TIMEOUT_EN
          else if (to_cnt_q == TW'(TIMEOUT_POLLS - 1)) state_d = STOP;
`endif
          else state_d = POLL_WAIT;
        end
      end
      ACK_SET: begin
        m_write      = 1'b1;
        m_chipselect = 1'b1;
        m_addr       = mk_addr(OP_READ, 9'd0);
        m_writedata  = DATA_WIDTH'(1);
        state_d      = FETCH;
      end
      FETCH: begin
        // Address stays up through setup, strobe and sample; only ph 1 strobes
        m_addr = mk_addr(sel_q ? OP_RY : OP_RX, 9'(body_q));
        if (ph_q == 2'd1) begin
          m_read       = 1'b1;
          m_chipselect = 1'b1;
        end
        if (ph_q == 2'd3 && out_valid_q && out_ready && sel_q && body_last) state_d = ACK_CLR;
      end
      ACK_CLR: begin
        m_write      = 1'b1;
        m_chipselect = 1'b1;
        m_addr       = mk_addr(OP_READ, 9'd0);
        state_d      = (frame_q != frames_m1_q) ? POLL_WAIT : STOP;
      end
      STOP: begin
        m_write      = 1'b1;
        m_chipselect = 1'b1;
        m_addr       = mk_addr(OP_GO, 9'd0);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      body_q      <= '0;
      frame_q     <= '0;
      idx_q       <= '0;
      ph_q        <= '0;
      sel_q       <= 1'b0;
      gcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
`ifdef NBODY_HOST_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      error_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (start_ok) begin
            frame_q <= '0;
            idx_q   <= '0;
            body_q  <= '0;
`ifdef NBODY_HOST_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else begin
            error_q <= 1'b1;
          end
        end
        CFG: idx_q <= (idx_q == 3'd3) ? 3'd0 : idx_q + 3'd1;
        LOAD: if (in_valid) begin
          if (idx_q == 3'd4) begin
            idx_q <= 3'd0;
            if (!body_last) body_q <= body_q + 1'b1;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        GO: gcnt_q <= '0;
        POLL_WAIT: begin
          if (gcnt_q == GW'(POLL_GAP - 1)) begin
            gcnt_q <= '0;
            ph_q   <= '0;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        POLL: begin
          if (ph_q == 2'd2) begin
            ph_q   <= '0;
            gcnt_q <= '0;
`ifdef NBODY_HOST_TIMEOUT_EN
            if (m_readdata[0]) begin
              to_cnt_q <= '0;
            end else if (to_cnt_q == TW'(TIMEOUT_POLLS - 1)) begin
              to_cnt_q <= '0;
              error_q  <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
          end else begin
            ph_q <= ph_q + 2'd1;
          end
        end
        ACK_SET: begin
          body_q <= '0;
          sel_q  <= 1'b0;
          ph_q   <= '0;
        end
        FETCH: begin
          case (ph_q)
            2'd2: begin
              out_data_q  <= m_readdata;
              out_valid_q <= 1'b1;
              out_last_q  <= sel_q && body_last;
              ph_q        <= 2'd3;
            end
            2'd3: if (out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              ph_q        <= 2'd0;
              if (!sel_q) begin
                sel_q <= 1'b1;
              end else begin
                sel_q <= 1'b0;
                if (!body_last) body_q <= body_q + 1'b1;
              end
            end
            default: ph_q <= ph_q + 2'd1;
          endcase
        end
        ACK_CLR: begin
          gcnt_q <= '0;
          if (frame_q != frames_m1_q) frame_q <= frame_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
